// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider family.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 28;
  localparam int unsigned DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, compare/subtract.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] p_i,
  input  logic             q_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] p_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] t;

  // T is WIDTH+1 bits wide so a carry out of P[W-1] still takes part in the compare.
  always_comb begin
    t       = {p_i, q_bit_i};
    q_bit_o = (t >= {1'b0, divisor_i});
    p_o     = q_bit_o ? WIDTH'(t - {1'b0, divisor_i}) : t[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_restoring_seq.sv
// Iterative restoring divider, 2*WIDTH / WIDTH, one quotient bit per clock.
// Optional early-exit overflow detection enabled by defining DIV_OVF_DETECT_EN.
module divider_restoring_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div0,
  output logic               ovf
);

  localparam int unsigned CNT_W =
    ($clog2(WIDTH) > DIV_CNT_W) ? $clog2(WIDTH) : DIV_CNT_W;

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  // P's top bit never feeds T or the remainder, so only its low WIDTH bits are kept.
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, dvs_q;
  logic             qbit_d;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             busy_q, done_q, div0_q, ovf_q;
  logic             early_ovf;
  logic             last_iter;

`ifdef DIV_OVF_DETECT_EN
  assign early_ovf = (divisor != '0) && (dividend[2*WIDTH-1:WIDTH] >= divisor);
`else
  assign early_ovf = 1'b0;
`endif

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p_i       (p_q),
    .q_bit_i   (q_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .p_o       (p_d),
    .q_bit_o   (qbit_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            dvs_q  <= divisor;
            p_q    <= dividend[2*WIDTH-1:WIDTH];
            q_q    <= dividend[WIDTH-1:0];
            cnt_q  <= '0;
            div0_q <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (divisor == '0) begin
              state_q <= DIV_DONE;
              done_q  <= 1'b1;
              quot_q  <= '1;
              rem_q   <= dividend[WIDTH-1:0];
              div0_q  <= 1'b1;
            end else if (early_ovf) begin
              state_q <= DIV_DONE;
              done_q  <= 1'b1;
              quot_q  <= '1;
              rem_q   <= dividend[WIDTH-1:0];
              ovf_q   <= 1'b1;
            end else begin
              state_q <= DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          p_q   <= p_d;
          q_q   <= {q_q[WIDTH-2:0], qbit_d};
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            state_q <= DIV_DONE;
            done_q  <= 1'b1;
            quot_q  <= {q_q[WIDTH-2:0], qbit_d};
            rem_q   <= p_d;
          end
        end
        DIV_DONE: begin
          state_q <= DIV_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= DIV_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div0      = div0_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_divider_restoring_seq.sv
// Scoreboard bench for divider_restoring_seq against an arithmetic reference model.
module tb_divider_restoring_seq;

  localparam int unsigned W = 28;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy, done, div0, ovf;
  logic [W-1:0]   quotient, remainder;

  divider_restoring_seq #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         div0;
    logic         ovf;
    logic         chk_vals;
    int unsigned  lat;
    int unsigned  t0;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t model(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
    exp_t            e;
    longint unsigned n = longint'(dvd);
    longint unsigned d = longint'(dvs);
    e.div0 = 1'b0; e.ovf = 1'b0; e.chk_vals = 1'b1; e.lat = W; e.t0 = 0;
    e.q = '0; e.r = '0;
    if (d == 0) begin
      e.div0 = 1'b1; e.q = '1; e.r = dvd[W-1:0]; e.lat = 0;
    end else if ((n / d) >= (64'd1 << W)) begin
`ifdef DIV_OVF_DETECT_EN
      e.ovf = 1'b1; e.q = '1; e.r = dvd[W-1:0]; e.lat = 0;
`else
      e.chk_vals = 1'b0;
`endif
    end else begin
      e.q = W'(n / d);
      e.r = W'(n % d);
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic issue(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                       input bit push, input bit hold);
    int unsigned n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("wait_idle_timeout", busy, 0);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    if (push) begin
      exp_t e = model(dvd, dvs);
      e.t0 = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  initial begin : monitor
    bit   prev_done = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_done = 1'b0;
        continue;
      end
      if (prev_done) begin
        chk("done_pulse_width", done, 0);
        chk("idle_after_done", busy, 0);
      end
      prev_done = done;
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          e = sb.pop_front();
          chk("latency", 64'(cyc - e.t0 - 1), 64'(e.lat));
          chk("busy_at_done", busy, 1);
          chk("div0", div0, e.div0);
          chk("ovf", ovf, e.ovf);
          if (e.chk_vals) begin
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [W-1:0]    a, b, dv, hi, lo;
    longint unsigned prod;
    int unsigned     n;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_div0", div0, 0);
    chk("reset_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;

    issue(56'd100, 28'd7, 1, 0);
    issue(56'd100, 28'd7, 1, 0);
    repeat (5) @(negedge clk);
    dividend = 56'd999; divisor = 28'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; dividend = '1; divisor = '0;

    issue(56'hFFFFFFE0000001, 28'hFFFFFFF, 1, 0);
    issue(56'h12345678ABCDEF, 28'd0, 1, 0);
    issue(56'h00000010000000, 28'd1, 1, 0);

    for (int i = 0; i < 100; i++) begin
      a    = W'($urandom);
      b    = W'($urandom_range(32'h0FFFFFFF, 1));
      prod = longint'(a) * longint'(b);
      issue(prod[2*W-1:0], b, 1, 0);
    end

    for (int i = 0; i < 40; i++) begin
      dv = W'($urandom);
      if (i % 4 == 0) dv = W'($urandom_range(255, 1));
      if (i % 13 == 5) dv = '0;
      if (dv != '0 && i % 9 != 3) hi = W'($urandom % dv);
      else hi = W'($urandom);
      lo = W'($urandom);
      issue({hi, lo}, dv, 1, 0);
    end

    issue(56'd12345, 28'd11, 0, 0);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_done", done, 0);
    chk("midrun_rst_quotient", quotient, 0);
    chk("midrun_rst_remainder", remainder, 0);
    chk("midrun_rst_div0", div0, 0);
    chk("midrun_rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    issue(56'd100, 28'd7, 1, 0);

    issue(56'd100, 28'd7, 1, 1);
    issue(56'h12345678ABCDEF, 28'd0, 1, 1);
    issue(56'h00000000000055, 28'd0, 1, 1);
    issue(56'd5000000, 28'd9, 1, 1);
    start = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
